// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target engine: FSM encoding,
// bus acknowledge levels and the read fill byte used when no data returns.
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_ACK_DEV,
    ST_AHI,
    ST_ACK_AHI,
    ST_ALO,
    ST_ACK_ALO,
    ST_WDATA,
    ST_ACK_W,
    ST_RDATA,
    ST_MACK
  } state_e;

  localparam logic       SDA_ACK      = 1'b0;
  localparam logic       SDA_NACK     = 1'b1;
  localparam logic [7:0] READ_DEFAULT = 8'hFF;

  function automatic logic [11:0] addr_inc(input logic [11:0] a);
    return a + 12'd1;
  endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchronizer, N-sample glitch filter and edge detector for one
// I2C line. Level only changes after FILT_LEN consecutive equal samples.
module i2c_line_filter #(
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [1:0]          sync_q;
  logic [FILT_LEN-1:0] hist_q;
  logic [FILT_LEN-1:0] hist_d;
  logic                level_q;
  logic                level_d;
  logic                rise_q;
  logic                fall_q;

  always_comb begin
    hist_d  = (hist_q << 1) | FILT_LEN'(sync_q[1]);
    level_d = level_q;
    if (&hist_q) begin
      level_d = 1'b1;
    end else if (~|hist_q) begin
      level_d = 1'b0;
    end
  end

  // Idle bus is high, so every stage presets to 1 to avoid a false edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= '1;
      hist_q  <= '1;
      level_q <= 1'b1;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], line_i};
      hist_q  <= hist_d;
      level_q <= level_d;
      rise_q  <= level_d & ~level_q;
      fall_q  <= ~level_d & level_q;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/i2c_slave_if.sv
// I2C target engine: decodes device/register-address bytes, issues write
// strobes and read requests to the register file, auto-increments the address.
module i2c_slave_if
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = 7'h1A,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [11:0] i2c_addr,
  output logic [7:0]  i2c_wdata,
  output logic        i2c_xfc_write,
  output logic        i2c_op,
  output logic        i2c_rd_req,
  input  logic [7:0]  i2c_rdata,
  input  logic        i2c_xfc_read
);

  logic scl_lvl, scl_rise, scl_fall;
  logic sda_lvl, sda_rise, sda_fall;
  logic start_det, stop_det;

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .line_i  (scl_in),
    .level_o (scl_lvl),
    .rise_o  (scl_rise),
    .fall_o  (scl_fall)
  );

  i2c_line_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
    .clk_i   (clk),
    .rst_ni  (rst),
    .line_i  (sda_in),
    .level_o (sda_lvl),
    .rise_o  (sda_rise),
    .fall_o  (sda_fall)
  );

  assign start_det = sda_fall & scl_lvl;
  assign stop_det  = sda_rise & scl_lvl;

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  sh_q, sh_d;
  logic        rw_q, rw_d;
  logic [3:0]  ahi_q, ahi_d;
  logic [11:0] addr_q, addr_d;
  logic [7:0]  wdata_q, wdata_d;
  logic        op_q, op_d;
  logic        xfc_write_q, xfc_write_d;
  logic        rd_req_q, rd_req_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  tx_q, tx_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        cap_q, cap_d;
  logic        loaded_q, loaded_d;

  logic        rx_state, ack_state, byte_done, last_bit, enter_rd;
  logic [7:0]  byte_in, tx_byte;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sh_d        = sh_q;
    rw_d        = rw_q;
    ahi_d       = ahi_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    op_d        = op_q;
    xfc_write_d = 1'b0;
    rd_req_d    = 1'b0;
    sda_oe_d    = sda_oe_q;
    tx_d        = tx_q;
    rdata_d     = rdata_q;
    cap_d       = cap_q;
    loaded_d    = loaded_q;
    enter_rd    = 1'b0;
    tx_byte     = tx_q;
    byte_in     = {sh_q[6:0], sda_lvl};
    last_bit    = (bit_cnt_q == 3'd7);
    rx_state    = (state_q == ST_DEV) || (state_q == ST_AHI) ||
                  (state_q == ST_ALO) || (state_q == ST_WDATA);
    ack_state   = (state_q == ST_ACK_DEV) || (state_q == ST_ACK_AHI) ||
                  (state_q == ST_ACK_ALO) || (state_q == ST_ACK_W);
    byte_done   = rx_state && scl_rise && last_bit;

    if (stop_det) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
    end else if (start_det) begin
      state_d   = ST_DEV;
      bit_cnt_d = '0;
      sda_oe_d  = 1'b0;
    end else begin
      if (rx_state) begin
        if (scl_fall) begin
          sda_oe_d = 1'b0;
        end
        if (scl_rise) begin
          sh_d      = byte_in;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      // ACK states are entered on the 8th rise, so the next edge is the fall.
      if (ack_state && scl_fall) begin
        sda_oe_d = ~SDA_ACK;
      end

      unique case (state_q)
        ST_IDLE: sda_oe_d = 1'b0;
        ST_DEV: begin
          if (byte_done) begin
            if (byte_in[7:1] == DEV_ADDR) begin
              rw_d    = byte_in[0];
              state_d = ST_ACK_DEV;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_AHI: begin
          if (byte_done) begin
            if (byte_in[7:4] == 4'h0) begin
              ahi_d   = byte_in[3:0];
              state_d = ST_ACK_AHI;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
        ST_ALO: begin
          if (byte_done) begin
            state_d = ST_ACK_ALO;
          end
        end
        ST_WDATA: begin
          if (byte_done) begin
            wdata_d     = byte_in;
            op_d        = 1'b1;
            xfc_write_d = 1'b1;
            state_d     = ST_ACK_W;
          end
        end
        ST_ACK_DEV: begin
          if (scl_rise) begin
            if (rw_q) begin
              enter_rd = 1'b1;
            end else begin
              state_d = ST_AHI;
            end
          end
        end
        ST_ACK_AHI: begin
          if (scl_rise) begin
            state_d = ST_ALO;
          end
        end
        ST_ACK_ALO: begin
          if (scl_rise) begin
            addr_d  = {ahi_q, sh_q};
            state_d = ST_WDATA;
          end
        end
        ST_ACK_W: begin
          if (scl_rise) begin
            addr_d  = addr_inc(addr_q);
            state_d = ST_WDATA;
          end
        end
        ST_RDATA: begin
          // Read data is accepted only until the first bit is driven out.
          if (!loaded_q && !cap_q && i2c_xfc_read) begin
            rdata_d = i2c_rdata;
            cap_d   = 1'b1;
          end
          if (scl_fall) begin
            if (loaded_q) begin
              tx_byte = tx_q;
            end else if (cap_q) begin
              tx_byte = rdata_q;
            end else if (i2c_xfc_read) begin
              tx_byte = i2c_rdata;
            end else begin
              tx_byte = READ_DEFAULT;
            end
            sda_oe_d = ~tx_byte[7];
            tx_d     = {tx_byte[6:0], 1'b0};
            loaded_d = 1'b1;
          end
          if (scl_rise && loaded_q) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
              state_d = ST_MACK;
            end
          end
        end
        ST_MACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
          end
          if (scl_rise) begin
            if (sda_lvl == SDA_NACK) begin
              state_d = ST_IDLE;
            end else begin
              addr_d   = addr_inc(addr_q);
              enter_rd = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (enter_rd) begin
        state_d   = ST_RDATA;
        bit_cnt_d = '0;
        op_d      = 1'b0;
        rd_req_d  = 1'b1;
        cap_d     = 1'b0;
        loaded_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      sh_q        <= '0;
      rw_q        <= 1'b0;
      ahi_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      op_q        <= 1'b0;
      xfc_write_q <= 1'b0;
      rd_req_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      tx_q        <= '1;
      rdata_q     <= '0;
      cap_q       <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sh_q        <= sh_d;
      rw_q        <= rw_d;
      ahi_q       <= ahi_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      op_q        <= op_d;
      xfc_write_q <= xfc_write_d;
      rd_req_q    <= rd_req_d;
      sda_oe_q    <= sda_oe_d;
      tx_q        <= tx_d;
      rdata_q     <= rdata_d;
      cap_q       <= cap_d;
      loaded_q    <= loaded_d;
    end
  end

  assign sda_oe        = sda_oe_q;
  assign i2c_addr      = addr_q;
  assign i2c_wdata     = wdata_q;
  assign i2c_xfc_write = xfc_write_q;
  assign i2c_op        = op_q;
  assign i2c_rd_req    = rd_req_q;

endmodule

// File: tb/tb_i2c_slave_if.sv
// Bench for i2c_slave_if: bit-banged I2C master, register-file read model,
// and a scoreboard monitor checking write strobes and read requests.
module tb_i2c_slave_if;
  import i2c_pkg::*;

  localparam int unsigned Q = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl_in, sda_in, sda_oe;
  logic [11:0] i2c_addr;
  logic [7:0]  i2c_wdata;
  logic        i2c_xfc_write, i2c_op, i2c_rd_req;
  logic [7:0]  i2c_rdata;
  logic        i2c_xfc_read;

  logic scl_m, sda_m;
  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_slave_if #(.DEV_ADDR(7'h1A), .FILT_LEN(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .scl_in        (scl_in),
    .sda_in        (sda_in),
    .sda_oe        (sda_oe),
    .i2c_addr      (i2c_addr),
    .i2c_wdata     (i2c_wdata),
    .i2c_xfc_write (i2c_xfc_write),
    .i2c_op        (i2c_op),
    .i2c_rd_req    (i2c_rd_req),
    .i2c_rdata     (i2c_rdata),
    .i2c_xfc_read  (i2c_xfc_read)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t         wr_q[$];
  logic [11:0] rd_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [7:0]  mem [4096];
  logic        resp_en;
  logic        oe_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b1; wclk(Q);
  endtask

  task automatic bit_out(input logic b, input logic glitch);
    sda_m = b;
    if (glitch) begin
      wclk(3); scl_m = 1'b1; wclk(1); scl_m = 1'b0; wclk(Q - 4);
    end else begin
      wclk(Q);
    end
    scl_m = 1'b1; wclk(2 * Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic bit_in(output logic b);
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    b = sda_in;   wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic write_byte(input logic [7:0] v, input int gbit, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) bit_out(v[i], i == gbit);
    bit_in(b);
    ack = (b == SDA_ACK);
  endtask

  task automatic wb(input string name, input logic [7:0] v, input logic exp_ack);
    logic a;
    write_byte(v, -1, a);
    chk(name, a, exp_ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(ack ? SDA_ACK : SDA_NACK, 1'b0);
  endtask

  // Register-file read model: answers a request three clocks later.
  initial begin
    int          dly;
    logic [11:0] ra;
    dly = 0; ra = '0;
    i2c_xfc_read = 1'b0;
    i2c_rdata    = '0;
    forever begin
      @(negedge clk);
      i2c_xfc_read = 1'b0;
      if (dly > 0) begin
        dly--;
        if (dly == 0) begin
          i2c_xfc_read = 1'b1;
          i2c_rdata    = mem[ra];
        end
      end
      if (i2c_rd_req && resp_en) begin
        dly = 3;
        ra  = i2c_addr;
      end
    end
  end

  // Scoreboard monitor: every strobe must match the oldest expected entry.
  initial begin
    wr_t         e;
    logic [11:0] ea;
    forever begin
      @(negedge clk);
      if (sda_oe === 1'b1) oe_seen = 1'b1;
      if (i2c_xfc_write === 1'b1) begin
        chk("wr_expected", wr_q.size() != 0, 1);
        if (wr_q.size() != 0) begin
          e = wr_q.pop_front();
          chk("wr_addr", i2c_addr, e.addr);
          chk("wr_data", i2c_wdata, e.data);
          chk("wr_op", i2c_op, 1);
        end
      end
      if (i2c_rd_req === 1'b1) begin
        chk("rd_expected", rd_q.size() != 0, 1);
        if (rd_q.size() != 0) begin
          ea = rd_q.pop_front();
          chk("rd_addr", i2c_addr, ea);
          chk("rd_op", i2c_op, 0);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic [7:0] dev_w;
    logic       a;
    rst = 1'b0; scl_m = 1'b1; sda_m = 1'b1; resp_en = 1'b1; oe_seen = 1'b0;
    mem[12'h010] = 8'h11;
    mem[12'h011] = 8'h22;
    dev_w = 8'h34;
    wclk(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_addr", i2c_addr, 0);
    chk("rst_wdata", i2c_wdata, 0);
    chk("rst_xfc_write", i2c_xfc_write, 0);
    chk("rst_op", i2c_op, 0);
    chk("rst_rd_req", i2c_rd_req, 0);
    rst = 1'b1; wclk(10);

    // Write burst 0x123: A5, 0x124: 5A
    i2c_start();
    wb("wr_ack_dev", 8'h34, 1);
    wb("wr_ack_ahi", 8'h01, 1);
    wb("wr_ack_alo", 8'h23, 1);
    wr_q.push_back('{12'h123, 8'hA5});
    wb("wr_ack_d0", 8'hA5, 1);
    wr_q.push_back('{12'h124, 8'h5A});
    wb("wr_ack_d1", 8'h5A, 1);
    i2c_stop();
    chk("burst_op", i2c_op, 1);
    chk("burst_addr_end", i2c_addr, 12'h125);

    // Set address 0x010, repeated start, read two bytes
    i2c_start();
    wb("rd_ack_dev_w", 8'h34, 1);
    wb("rd_ack_ahi", 8'h00, 1);
    wb("rd_ack_alo", 8'h10, 1);
    i2c_start();
    rd_q.push_back(12'h010);
    wb("rd_ack_dev_r", 8'h35, 1);
    rd_q.push_back(12'h011);
    read_byte(d, 1'b1);
    chk("rd_byte0", d, 8'h11);
    read_byte(d, 1'b0);
    chk("rd_byte1", d, 8'h22);
    chk("rd_state_idle", 32'(dut.state_q), 32'(ST_IDLE));
    chk("rd_op", i2c_op, 0);
    chk("rd_addr_end", i2c_addr, 12'h011);
    i2c_stop();

    // Device address mismatch
    i2c_start();
    oe_seen = 1'b0;
    wb("mis_noack_dev", 8'h30, 0);
    wb("mis_noack_b1", 8'h00, 0);
    chk("mis_sda_oe_seen", oe_seen, 0);
    i2c_stop();

    // Address wrap 0xFFF -> 0x000
    i2c_start();
    wb("wrap_ack_dev", 8'h34, 1);
    wb("wrap_ack_ahi", 8'h0F, 1);
    wb("wrap_ack_alo", 8'hFF, 1);
    wr_q.push_back('{12'hFFF, 8'h01});
    wb("wrap_ack_d0", 8'h01, 1);
    wr_q.push_back('{12'h000, 8'h02});
    wb("wrap_ack_d1", 8'h02, 1);
    i2c_stop();

    // High address byte with nonzero upper nibble
    i2c_start();
    wb("bad_ahi_ack_dev", 8'h34, 1);
    wb("bad_ahi_nack", 8'h10, 0);
    i2c_stop();

    // Read with no data returned -> fill byte
    resp_en = 1'b0;
    i2c_start();
    wb("nr_ack_dev_w", 8'h34, 1);
    wb("nr_ack_ahi", 8'h00, 1);
    wb("nr_ack_alo", 8'h40, 1);
    i2c_start();
    rd_q.push_back(12'h040);
    wb("nr_ack_dev_r", 8'h35, 1);
    read_byte(d, 1'b0);
    chk("nr_byte", d, 8'hFF);
    i2c_stop();
    resp_en = 1'b1;

    // STOP after four data bits: byte dropped
    i2c_start();
    wb("part_ack_dev", 8'h34, 1);
    wb("part_ack_ahi", 8'h02, 1);
    wb("part_ack_alo", 8'h00, 1);
    for (int i = 0; i < 4; i++) bit_out(1'b1, 1'b0);
    i2c_stop();
    chk("part_wdata_kept", i2c_wdata, 8'h02);

    // Reset while the ACK is being driven
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_out(dev_w[i], 1'b0);
    sda_m = 1'b1;
    chk("ack_driven_pre_rst", sda_oe, 1);
    #2 rst = 1'b0;
    #1 chk("rst_mid_ack_sda_oe", sda_oe, 0);
    scl_m = 1'b1; sda_m = 1'b1;
    wclk(5);
    rst = 1'b1;
    wclk(20);
    chk("rst_mid_addr", i2c_addr, 0);

    // One-clock SCL glitch inside a data bit
    i2c_start();
    wb("gl_ack_dev", 8'h34, 1);
    wb("gl_ack_ahi", 8'h00, 1);
    wb("gl_ack_alo", 8'h50, 1);
    wr_q.push_back('{12'h050, 8'h3C});
    write_byte(8'h3C, 3, a);
    chk("gl_ack_data", a, 1);
    i2c_stop();
    chk("gl_wdata", i2c_wdata, 8'h3C);

    wclk(20);
    chk("wr_left", wr_q.size(), 0);
    chk("rd_left", rd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
